// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller: one outstanding req/gnt/rvalid data-memory access with
// lane alignment, sign/zero extension, misalignment, bus-error and timeout reporting.
module dmem_lsu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [1:0]        i_lsu_size,
  input  logic              i_lsu_sign,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  output logic              o_lsu_busy,
  output logic              o_lsu_done,
  output logic [31:0]       o_lsu_rdata,
  output logic              o_lsu_err,
  output logic              o_lsu_misaligned,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i,
  input  logic              data_err_i,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o
);

  // Handshake: data_req_o stays high with addr/we/be/wdata stable until the
  // cycle data_gnt_i is seen; the single response is the next data_rvalid_i.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          off_q, off_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mis_q, mis_d;

  logic                req_mis;
  logic                req_illegal;
  logic [3:0]          be_calc;
  logic [31:0]         wdata_calc;
  logic [31:0]         load_shift;
  logic [31:0]         load_ext;
  logic [TO_CNT_W-1:0] cnt_nxt;
  logic                to_hit;

  always_comb begin
    req_illegal = (i_lsu_size == 2'b11);
    req_mis     = ((i_lsu_size == 2'b01) && i_lsu_addr[0]) ||
                  ((i_lsu_size == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
    be_calc     = 4'b1111;
    wdata_calc  = i_lsu_wdata;
    case (i_lsu_size)
      2'b00: begin
        be_calc    = 4'b0001 << i_lsu_addr[1:0];
        wdata_calc = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << i_lsu_addr[1:0];
        wdata_calc = {2{i_lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_shift = data_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_ext = {{16{sign_q & load_shift[15]}}, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt_q + TO_CNT_W'(1);
    to_hit  = (TIMEOUT_CYC != 0) && (cnt_nxt >= TO_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_lsu_req) begin
          if (req_illegal || req_mis) begin
            // Rejected accesses never touch the bus.
            state_d = S_DONE;
            err_d   = 1'b1;
            mis_d   = req_mis;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
            addr_d  = {i_lsu_addr[ADDR_W-1:2], 2'b00};
            off_d   = i_lsu_addr[1:0];
            be_d    = be_calc;
            wdata_d = wdata_calc;
            we_d    = i_lsu_we;
            size_d  = i_lsu_size;
            sign_d  = i_lsu_sign;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_nxt;
        // A grant on the timeout cycle still wins: the bus owns the access now.
        if (data_gnt_i) begin
          state_d = S_RESP;
        end else if (to_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          mis_d   = 1'b0;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        cnt_d = cnt_nxt;
        if (data_rvalid_i) begin
          state_d = S_DONE;
          err_d   = data_err_i;
          mis_d   = 1'b0;
          rdata_d = (data_err_i || we_q) ? 32'h0 : load_ext;
        end else if (to_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          mis_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign o_lsu_busy       = (state_q == S_REQ) || (state_q == S_RESP);
  assign o_lsu_done       = (state_q == S_DONE);
  assign o_lsu_rdata      = rdata_q;
  assign o_lsu_err        = err_q;
  assign o_lsu_misaligned = mis_q;
  assign data_req_o       = (state_q == S_REQ);
  assign data_we_o        = we_q;
  assign data_be_o        = be_q;
  assign data_addr_o      = addr_q;
  assign data_wdata_o     = wdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl: drivers push expected {err, misaligned, rdata}
// into a queue, a negedge monitor pops it on every o_lsu_done pulse.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_lsu_req, i_lsu_we, i_lsu_sign;
  logic [1:0]  i_lsu_size;
  logic [31:0] i_lsu_addr, i_lsu_wdata;
  logic        o_lsu_busy, o_lsu_done, o_lsu_err, o_lsu_misaligned;
  logic [31:0] o_lsu_rdata;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [31:0] data_rdata_i, data_wdata_o, data_addr_o;
  logic [3:0]  data_be_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  int          to_n;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4), .TO_CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_size(i_lsu_size),
    .i_lsu_sign(i_lsu_sign), .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
    .o_lsu_busy(o_lsu_busy), .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_err(o_lsu_err), .o_lsu_misaligned(o_lsu_misaligned),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_i && o_lsu_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_rdata", o_lsu_rdata, mon_e[31:0]);
        chk("done_err", {31'b0, o_lsu_err}, {31'b0, mon_e[33]});
        chk("done_misaligned", {31'b0, o_lsu_misaligned}, {31'b0, mon_e[32]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push, input logic [33:0] exp);
    i_lsu_req   = 1'b1;
    i_lsu_we    = we;
    i_lsu_size  = size;
    i_lsu_sign  = sign;
    i_lsu_addr  = addr;
    i_lsu_wdata = wdata;
    if (push) exp_q.push_back(exp);
    tick();
    i_lsu_req = 1'b0;
  endtask

  task automatic serve(input int gnt_dly, input logic [31:0] rdata, input logic rerr,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input logic e_we);
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("req_high", {31'b0, data_req_o}, 32'd1);
      chk("busy_req", {31'b0, o_lsu_busy}, 32'd1);
      chk("bus_addr", data_addr_o, e_addr);
      chk("bus_be", {28'b0, data_be_o}, {28'b0, e_be});
      chk("bus_wdata", data_wdata_o, e_wdata);
      chk("bus_we", {31'b0, data_we_o}, {31'b0, e_we});
      data_gnt_i = (i == gnt_dly);
      tick();
    end
    data_gnt_i = 1'b0;
    chk("req_drop_after_gnt", {31'b0, data_req_o}, 32'd0);
    chk("busy_resp", {31'b0, o_lsu_busy}, 32'd1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = rerr;
    tick();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_err_i    = 1'b0;
    chk("done_pulse", {31'b0, o_lsu_done}, 32'd1);
    chk("busy_done", {31'b0, o_lsu_busy}, 32'd0);
  endtask

  task automatic chk_rejected();
    chk("reject_done", {31'b0, o_lsu_done}, 32'd1);
    chk("reject_no_req", {31'b0, data_req_o}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {22'b0, o_lsu_busy, o_lsu_done, o_lsu_err, o_lsu_misaligned,
               data_req_o, data_we_o, data_be_o}, 32'd0);
    chk({name, "_addr"}, data_addr_o, 32'd0);
    chk({name, "_wdata"}, data_wdata_o, 32'd0);
    chk({name, "_rdata"}, o_lsu_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; i_lsu_req = 1'b0; i_lsu_we = 1'b0; i_lsu_size = 2'b00;
    i_lsu_sign = 1'b0; i_lsu_addr = '0; i_lsu_wdata = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
    tick();
    chk_all_zero("reset_state");
    tick();
    rst_i = 1'b0;
    tick();

    // Aligned LW, minimum latency
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, {2'b00, 32'hDEADBEEF});
    serve(0, 32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 32'h0, 1'b0);
    tick();

    // LB signed / unsigned at lane 3
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, {2'b00, 32'hFFFFFF80});
    serve(0, 32'h80FFFF00, 1'b0, 32'h100, 4'b1000, 32'h0, 1'b0);
    tick();
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, {2'b00, 32'h00000080});
    serve(0, 32'h80FFFF00, 1'b0, 32'h100, 4'b1000, 32'h0, 1'b0);
    tick();

    // SH with grant held off three cycles
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 1'b1, {2'b00, 32'h0});
    serve(3, 32'h12345678, 1'b0, 32'h100, 4'b1100, 32'hABCDABCD, 1'b1);
    tick();

    // SB lane 1, LH signed lane 2
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 1'b1, {2'b00, 32'h0});
    serve(1, 32'h0, 1'b0, 32'h100, 4'b0010, 32'hA5A5A5A5, 1'b1);
    tick();
    issue(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1'b1, {2'b00, 32'hFFFF8001});
    serve(2, 32'h80010000, 1'b0, 32'h104, 4'b1100, 32'h0, 1'b0);
    tick();

    // Rejected accesses: misaligned word, misaligned half, illegal size
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, {2'b11, 32'h0});
    chk_rejected();
    tick();
    issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1'b1, {2'b11, 32'h0});
    chk_rejected();
    tick();
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, {2'b10, 32'h0});
    chk_rejected();
    tick();

    // Bus error on response
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1, {2'b10, 32'h0});
    serve(0, 32'h00000055, 1'b1, 32'h104, 4'b1111, 32'h0, 1'b0);
    tick();

    // Back-to-back: second request sampled in DONE
    issue(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 1'b1, {2'b00, 32'h11223344});
    serve(0, 32'h11223344, 1'b0, 32'h108, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h10A, 32'h0, 1'b1, {2'b00, 32'h0000BEEF});
    serve(0, 32'hBEEF1234, 1'b0, 32'h108, 4'b1100, 32'h0, 1'b0);
    tick();

    // Timeout with no grant, then a stray rvalid
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, {2'b10, 32'h0});
    to_n = 0;
    while (data_req_o && to_n < 10) begin
      to_n++;
      tick();
    end
    chk("timeout_req_cycles", to_n, 32'd4);
    chk("timeout_done", {31'b0, o_lsu_done}, 32'd1);
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hCAFEF00D;
    tick();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    chk("late_rvalid_no_done", {31'b0, o_lsu_done}, 32'd0);
    chk("late_rvalid_idle", {31'b0, o_lsu_busy}, 32'd0);
    tick();

    // Reset while waiting for the response
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 34'h0);
    chk("rst_test_req", {31'b0, data_req_o}, 32'd1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("rst_test_resp", {31'b0, o_lsu_busy}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_all_zero("mid_reset");
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h00000077;
    tick();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    chk("post_reset_no_done", {31'b0, o_lsu_done}, 32'd0);
    chk("post_reset_idle", {31'b0, o_lsu_busy}, 32'd0);
    tick();

    // LBU lane 2 after reset
    issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b1, {2'b00, 32'h000000AB});
    serve(0, 32'h00AB0000, 1'b0, 32'h100, 4'b0100, 32'h0, 1'b0);
    repeat (3) tick();

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Sequential load/store controller between the core execute stage and the data-memory port.
- Replaces the combinational data-memory glue with a real req/gnt/rvalid handshake:
  - one outstanding transaction
  - byte/half/word accesses with byte enables
  - lane alignment, sign/zero extension
  - misalignment detection, bus-error reporting, response timeout.
- Core holds the pipeline while o_lsu_busy is high and consumes the result on the o_lsu_done pulse.

Parameters:
- ADDR_W, 32, width of core and bus address.
- TIMEOUT_CYC, 64, cycles allowed in REQ+RESP before abort; 0 disables the timeout.
- TO_CNT_W, 8, timeout counter width; must hold TIMEOUT_CYC.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- i_lsu_req  in  1  access request from core; sampled in IDLE or DONE.
- i_lsu_we  in  1  1=store, 0=load.
- i_lsu_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- i_lsu_sign  in  1  load sign-extend (1) or zero-extend (0).
- i_lsu_addr  in  ADDR_W  byte address.
- i_lsu_wdata  in  32  store data, LSB-aligned.
- o_lsu_busy  out  1  transaction in REQ or RESP.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_rdata  out  32  extended load data; valid with done.
- o_lsu_err  out  1  error flag; valid with done.
- o_lsu_misaligned  out  1  misalignment flag; valid with done.
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  bus grant.
- data_rvalid_i  in  1  response valid.
- data_rdata_i  in  32  response data.
- data_err_i  in  1  response error; qualified by rvalid.
- data_we_o  out  1  bus write enable.
- data_be_o  out  4  byte enables.
- data_addr_o  out  ADDR_W  word-aligned bus address; [1:0]=00.
- data_wdata_o  out  32  lane-replicated store data.

Behaviour:
- Reset values: FSM=IDLE and all outputs 0, at the first clock edge with rst_i=1. Reset mid-transaction abandons it: no done pulse; any later rvalid is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE/DONE + i_lsu_req:
  - aligned, legal size: register addr/be/wdata/we, go to REQ.
  - otherwise: go to DONE with err=1.
    - misaligned: half with addr[0]=1, or word with addr[1:0]!=00; misaligned=1.
    - size 11: misaligned=0.
    - No bus request is issued in either case.
- REQ: data_req_o=1; addr/we/be/wdata held stable until the cycle data_gnt_i=1, then go to RESP. data_req_o deasserts the cycle after gnt.
- RESP: wait for data_rvalid_i; capture data and err, then go to DONE.
- DONE: o_lsu_done=1 for exactly one cycle, then IDLE unless a new request is sampled. Back-to-back accesses therefore need no idle cycle.
- Minimum load/store latency: request sampled at cycle 0, data_req_o at 1, gnt at 1, rvalid at 2, done at 3.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Store data: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata.
- Load data:
  - shift data_rdata_i right by 8*addr[1:0];
  - byte extends from bit 7, half from bit 15, using i_lsu_sign captured at acceptance;
  - word passes through.
- o_lsu_rdata=0 for stores and for any error.
- data_err_i with rvalid: o_lsu_err=1, o_lsu_rdata=0.
- Timeout:
  - counter clears on acceptance and increments each cycle in REQ/RESP.
  - On reaching TIMEOUT_CYC (≠0): drop data_req_o, go to DONE with err=1, misaligned=0.
  - data_rvalid_i in IDLE/DONE is ignored.
- o_lsu_busy = state in {REQ, RESP}. i_lsu_req while busy is ignored; the core must hold it.
- o_lsu_err, o_lsu_misaligned, o_lsu_rdata hold their last values outside DONE; checks apply only with done.

Test Plan:
- Aligned LW addr 0x100, gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF -> data_addr_o=0x100, be=1111, done at cycle 3, rdata=0xDEADBEEF, err=0.
- LB signed addr 0x103, rdata 0x80FF_FF00 -> be=1000, rdata=0xFFFFFF80; same access unsigned -> 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD, gnt delayed 3 cycles -> req/addr/be=1100/wdata=0xABCDABCD stable all 4 REQ cycles, data_we_o=1, done after rvalid, rdata=0.
- LW addr 0x101 -> no data_req_o, done 1 cycle later, err=1, misaligned=1; size 11 -> err=1, misaligned=0.
- TIMEOUT_CYC=4, gnt never asserted -> data_req_o for 4 cycles, then done with err=1; a late rvalid is ignored.
- rvalid with data_err_i=1 -> err=1, rdata=0. Two back-to-back requests (second sampled in DONE) -> second data_req_o the cycle after first done. rst_i asserted in RESP -> all outputs 0 next edge, no done.
